l2_bias_accum: RTL

- Layer-2 output-neuron accumulator for 4 channels.
- Consumes the 4 registered 9-bit signed biases from the layer-2 bias ROM and a stream of signed per-channel products from the layer-2 multiplier array.
- After N_IN valid products per channel, it adds the scaled bias, applies ReLU, shifts and saturates, then presents 4 activations with a one-cycle valid pulse to the layer-3 input buffer.

---
 rtl/l2_bias_accum.sv | 132 +++++++++++++
 1 files changed

// File: rtl/l2_bias_accum.sv
// Layer-2 output-neuron accumulator: sums N_IN signed products per channel, adds the
// scaled bias, then applies ReLU, a right shift and saturation to produce 4 activations.
module l2_bias_accum #(
  parameter int N_IN       = 16,
  parameter int PROD_W     = 18,
  parameter int ACC_W      = 24,
  parameter int BIAS_SHIFT = 4,
  parameter int OUT_SHIFT  = 2,
  parameter int OUT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_data_0,
  input  logic [PROD_W-1:0] in_data_1,
  input  logic [PROD_W-1:0] in_data_2,
  input  logic [PROD_W-1:0] in_data_3,
  input  logic [8:0]        bias_0,
  input  logic [8:0]        bias_1,
  input  logic [8:0]        bias_2,
  input  logic [8:0]        bias_3,
  output logic              busy,
  output logic              out_valid,
  output logic [OUT_W-1:0]  dout_0,
  output logic [OUT_W-1:0]  dout_1,
  output logic [OUT_W-1:0]  dout_2,
  output logic [OUT_W-1:0]  dout_3
);

  localparam int NCH   = 4;
  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_BIAS, ST_OUT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ACC_W-1:0]   acc_q [NCH];
  logic [ACC_W-1:0]   acc_d [NCH];
  logic [OUT_W-1:0]   dout_q [NCH];
  logic [OUT_W-1:0]   dout_d [NCH];
  logic               out_valid_q, out_valid_d;

  logic [PROD_W-1:0]  in_data [NCH];
  logic [8:0]         bias    [NCH];
  logic [ACC_W-1:0]   shifted [NCH];

  assign in_data[0] = in_data_0;
  assign in_data[1] = in_data_1;
  assign in_data[2] = in_data_2;
  assign in_data[3] = in_data_3;
  assign bias[0]    = bias_0;
  assign bias[1]    = bias_1;
  assign bias[2]    = bias_2;
  assign bias[3]    = bias_3;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      acc_d[i]   = acc_q[i];
      dout_d[i]  = dout_q[i];
      shifted[i] = acc_q[i] >> OUT_SHIFT;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d = '0;
          for (int unsigned i = 0; i < NCH; i++) acc_d[i] = '0;
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < NCH; i++)
            acc_d[i] = acc_q[i] + {{(ACC_W-PROD_W){in_data[i][PROD_W-1]}}, in_data[i]};
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_IN - 1)) state_d = ST_BIAS;
        end
      end
      ST_BIAS: begin
        for (int unsigned i = 0; i < NCH; i++)
          acc_d[i] = acc_q[i] + ({{(ACC_W-9){bias[i][8]}}, bias[i]} << BIAS_SHIFT);
        state_d = ST_OUT;
      end
      ST_OUT: begin
        // Negative sums clamp to zero; anything above OUT_W bits after the shift saturates.
        for (int unsigned i = 0; i < NCH; i++) begin
          if (acc_q[i][ACC_W-1])
            dout_d[i] = '0;
          else if (shifted[i][ACC_W-1:OUT_W] != '0)
            dout_d[i] = '1;
          else
            dout_d[i] = shifted[i][OUT_W-1:0];
        end
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        acc_q[i]  <= acc_d[i];
        dout_q[i] <= dout_d[i];
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign dout_0    = dout_q[0];
  assign dout_1    = dout_q[1];
  assign dout_2    = dout_q[2];
  assign dout_3    = dout_q[3];

endmodule
